my_serial_adder: RTL

//   Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flip-flop, one bit per clock, LSB first.

---
 rtl/my_serial_adder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/my_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : my_serial_adder
// Description : Bit-serial WIDTH-bit adder, one full-adder slice and a carry
//               flop, LSB first, with a start/busy/done handshake.
//               Optional subtract mode is enabled by MY_SERIAL_ADDER_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module my_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MY_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last_bit;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;

    logic               sum_bit;
    logic               carry_next;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    // Operand B and the initial carry as captured on the accepting edge.
`ifdef MY_SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // New sum bits enter at the MSB so the result is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_acc_single
            assign acc_next = sum_bit;
        end else begin : g_acc_multi
            assign acc_next = {sum_bit, acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last_bit   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            r     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b_load;
                carry <= carry_load;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                carry <= carry_next;
                acc   <= acc_next;
                cnt   <= cnt + CNT_W'(1);
                // Visible outputs only change on completion, never mid-run.
                if (last_bit) begin
                    r    <= acc_next;
                    cout <= carry_next;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
